// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Used by inst_fetch_unit and, with INST_FETCH_ILLEGAL_CHECK_EN, by inst_legal_check.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [4:0] OP_LOAD   = 5'd0;
  localparam logic [4:0] OP_OPIMM  = 5'd4;
  localparam logic [4:0] OP_AUIPC  = 5'd5;
  localparam logic [4:0] OP_STORE  = 5'd8;
  localparam logic [4:0] OP_OP     = 5'd12;
  localparam logic [4:0] OP_LUI    = 5'd13;
  localparam logic [4:0] OP_BRANCH = 5'd24;
  localparam logic [4:0] OP_JALR   = 5'd25;
  localparam logic [4:0] OP_JAL    = 5'd27;

  localparam int INST_STEP = 4;

  function automatic logic opcode_is_legal(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: opcode_is_legal = 1'b1;
      default:                            opcode_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_legal_check.sv
// Combinational legality check of an instruction's low seven bits:
// a 32-bit encoding (bits [1:0] == 2'b11) with a supported major opcode.
module inst_legal_check
  import fetch_pkg::*;
(
  input  logic [6:0] inst_lo,
  output logic       legal
);

  always_comb begin
    legal = (inst_lo[1:0] == 2'b11) && opcode_is_legal(inst_lo[6:2]);
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding memory fetch, decode handshake, redirects.
// Optional macro INST_FETCH_ILLEGAL_CHECK_EN adds the illegal_inst output.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [4:0]        opcode_out,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef INST_FETCH_ILLEGAL_CHECK_EN
  output logic              illegal_inst,
`endif
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] redir_tgt;

  assign redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (redirect_valid && !imem_ack) state_d = DRAIN;
        else if (!redirect_valid && imem_ack) state_d = OUT;
      end
      OUT:   if (redirect_valid || inst_ready) state_d = REQ;
      DRAIN: if (imem_ack) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; a redirect always wins over the sequential pc+4.
  always_comb begin
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;
    target_d      = target_q;
    case (state_q)
      IDLE: if (redirect_valid) pc_d = redir_tgt;
      REQ: begin
        if (redirect_valid) begin
          if (imem_ack) pc_d = redir_tgt;
          else          target_d = redir_tgt;
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
        end
      end
      OUT: begin
        if (inst_ready) fetch_count_d = fetch_count_q + 32'd1;
        if (redirect_valid)  pc_d = redir_tgt;
        else if (inst_ready) pc_d = pc_q + ADDR_W'(INST_STEP);
      end
      DRAIN: begin
        if (redirect_valid) target_d = redir_tgt;
        if (imem_ack) pc_d = redirect_valid ? redir_tgt : target_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      fetch_count_q <= '0;
      target_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      fetch_count_q <= fetch_count_d;
      target_q      <= target_d;
    end
  end

  // pc_q is not touched while a request is pending, so it doubles as the held address.
  always_comb begin
    imem_req    = (state_q == REQ) || (state_q == DRAIN);
    imem_addr   = pc_q;
    inst_valid  = (state_q == OUT);
    inst_out    = inst_q;
    inst_pc     = inst_pc_q;
    opcode_out  = inst_q[6:2];
    fetch_count = fetch_count_q;
  end

`ifdef INST_FETCH_ILLEGAL_CHECK_EN
  logic inst_legal;

  inst_legal_check u_legal (
    .inst_lo (inst_q[6:0]),
    .legal   (inst_legal)
  );

  assign illegal_inst = inst_valid && !inst_legal;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of fetch order, data and counts.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [4:0]  opcode_out;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_count;
`ifdef INST_FETCH_ILLEGAL_CHECK_EN
  logic        illegal_inst;
`endif

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC), .INST_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .opcode_out     (opcode_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef INST_FETCH_ILLEGAL_CHECK_EN
    .illegal_inst   (illegal_inst),
`endif
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: where the next delivered instruction must come from.
  logic [31:0] exp_pc, exp_count, hold_addr;
  logic        exp_valid, exp_req, stale, req_pending, boot;
  int          wait_cnt, lat;
  logic        noise, rand_lat;

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h200: return 32'h0000_007F;
      32'h204: return 32'h0000_0003;
      default: begin
        h = a * 32'h9E37_79B1;
        return h ^ (a >> 3);
      end
    endcase
  endfunction

  function automatic logic legal_ref(input logic [31:0] w);
    logic [4:0] op;
    op = w[6:2];
    return (w[1:0] == 2'b11) &&
           (op inside {5'd0, 5'd4, 5'd5, 5'd8, 5'd12, 5'd13, 5'd24, 5'd25, 5'd27});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    exp_pc = RESET_PC; exp_count = 0; exp_valid = 0; exp_req = 0;
    stale = 0; req_pending = 0; boot = 1; wait_cnt = 0; hold_addr = 0;
  endtask

  // Called at a negedge: check outputs, drive inputs for the next posedge, advance model.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt, input logic fack);
    logic ack, xfer, acked, n_valid, n_req;
    chk("fetch_count", fetch_count, exp_count);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
    if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'b0);
    if (imem_req && !req_pending) chk("req_addr", imem_addr, exp_pc);
    if (imem_req && req_pending) chk("addr_hold", imem_addr, hold_addr);
    if (exp_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_out", inst_out, memf(exp_pc));
      chk("opcode_out", {27'b0, opcode_out}, {27'b0, memf(exp_pc) >> 2} & 32'h1F);
    end
`ifdef INST_FETCH_ILLEGAL_CHECK_EN
    chk("illegal_inst", {31'b0, illegal_inst},
        {31'b0, exp_valid && !legal_ref(memf(exp_pc))});
`endif
    inst_ready = rdy;
    redirect_valid = redir;
    redirect_pc = tgt;
    if (fack) ack = 1'b1;
    else if (imem_req) ack = (wait_cnt >= lat);
    else ack = noise && ($urandom_range(0, 1) == 1);
    imem_ack = ack;
    imem_rdata = imem_req ? memf(imem_addr) : $urandom;
    xfer  = inst_valid && rdy;
    acked = imem_req && ack;
    if (xfer) exp_count = exp_count + 1;
    n_valid = (acked && !stale && !redir) || (inst_valid && !rdy && !redir);
    n_req   = boot || (imem_req && !ack) || (inst_valid && (rdy || redir)) ||
              (acked && (stale || redir));
    if (redir) exp_pc = {tgt[31:2], 2'b00};
    else if (xfer) exp_pc = exp_pc + 32'd4;
    if (imem_req && !ack) begin
      stale = stale || redir;
      wait_cnt++;
      hold_addr = imem_addr;
    end else begin
      stale = 0;
    end
    if (acked) begin
      wait_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end
    req_pending = imem_req && !ack;
    boot = 0;
    exp_valid = n_valid;
    exp_req = n_req;
    @(negedge clk);
  endtask

  task automatic reset_seq(input logic late);
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = late;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'b0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'b0);
    chk("rst_inst_out", inst_out, 32'b0);
    chk("rst_inst_pc", inst_pc, 32'b0);
    chk("rst_opcode", {27'b0, opcode_out}, 32'b0);
    chk("rst_fetch_count", fetch_count, 32'b0);
`ifdef INST_FETCH_ILLEGAL_CHECK_EN
    chk("rst_illegal", {31'b0, illegal_inst}, 32'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  initial begin
    logic [31:0] c0, tgt;
    noise = 0; rand_lat = 0; lat = 0;
    model_init();

    // Zero-wait fetch of the first two words.
    reset_seq(1'b0);
    step(1, 0, 0, 0);
    chk("t1_addr0", imem_addr, 32'h0);
    step(1, 0, 0, 0);
    chk("t1_pc0", inst_pc, 32'h0);
    chk("t1_op0", {27'b0, opcode_out}, 32'd4);
    step(1, 0, 0, 0);
    chk("t1_addr4", imem_addr, 32'h4);
    step(1, 0, 0, 0);
    chk("t1_pc4", inst_pc, 32'h4);
    chk("t1_op4", {27'b0, opcode_out}, 32'd4);
    step(1, 0, 0, 0);
    chk("t1_count", fetch_count, 32'd2);

    // Backpressure on the instruction at 0x8.
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_req", {31'b0, imem_req}, 32'd0);
      chk("bp_pc", inst_pc, 32'h8);
      chk("bp_inst", inst_out, memf(32'h8));
      chk("bp_count", fetch_count, 32'd2);
      step(0, 0, 0, 0);
    end
    step(1, 0, 0, 0);

    // Request at 0xC with 3-cycle ack latency, redirected in its first wait cycle.
    lat = 2;
    chk("lr_addr_c", imem_addr, 32'hC);
    step(1, 1, 32'h103, 0);
    chk("lr_hold_req", {31'b0, imem_req}, 32'd1);
    chk("lr_hold_addr", imem_addr, 32'hC);
    step(1, 0, 0, 0);
    chk("lr_hold_addr2", imem_addr, 32'hC);
    step(1, 0, 0, 0);
    chk("lr_no_valid", {31'b0, inst_valid}, 32'd0);
    chk("lr_new_addr", imem_addr, 32'h100);
    lat = 0;

    // Redirect to 0x8, then redirect to 0x40 while that instruction transfers.
    step(1, 1, 32'h8, 0);
    chk("ro_addr8", imem_addr, 32'h8);
    step(1, 0, 0, 0);
    chk("ro_pc8", inst_pc, 32'h8);
    c0 = fetch_count;
    step(1, 1, 32'h40, 0);
    chk("ro_count", fetch_count, c0 + 32'd1);
    chk("ro_addr40", imem_addr, 32'h40);

    // Reset while draining, with an ack arriving late.
    lat = 3;
    step(1, 1, 32'h80, 0);
    step(1, 0, 0, 0);
    reset_seq(1'b1);
    lat = 0;
    step(1, 0, 0, 1);
    chk("rd_first_addr", imem_addr, RESET_PC);
    chk("rd_no_valid", {31'b0, inst_valid}, 32'd0);
    step(1, 0, 0, 0);
    chk("rd_inst", inst_out, memf(RESET_PC));

`ifdef INST_FETCH_ILLEGAL_CHECK_EN
    step(1, 1, 32'h200, 0);
    step(0, 0, 0, 0);
    chk("il_7f", {31'b0, illegal_inst}, 32'd1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("il_03", {31'b0, illegal_inst}, 32'd0);
    step(1, 0, 0, 0);
`endif

    // Randomized traffic: latencies, backpressure, redirects (some near the wrap point), stray acks.
    noise = 1; rand_lat = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = $urandom;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0, tgt, 1'b0);
    end
    step(1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Producer side of the instruction/decode interface.
- Holds the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Presents each fetched instruction, its PC and its opcode field inst[6:2] to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute. Sits between instruction memory and the control unit/decoder in the single-cycle-to-multicycle datapath.

Parameters:
- ADDR_W, 32, PC and memory address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- INST_W, 32, instruction width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch byte address, word aligned
- imem_ack  in  1  memory response strobe; imem_rdata valid this cycle
- imem_rdata  in  INST_W  fetched instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_out  out  INST_W  held instruction
- inst_pc  out  ADDR_W  PC of held instruction
- opcode_out  out  5  inst_out[6:2]
- redirect_valid  in  1  one-cycle pulse: change flow
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] forced to 0
- fetch_count  out  32  count of instructions handed to decode

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst_out=0, inst_pc=0, fetch_count=0, kill target=0.
- States:
  - IDLE: one cycle after reset release. Goes to REQ unconditionally.
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_ack: latch rdata to inst_out and pc to inst_pc, then go to OUT.
  - OUT: inst_valid=1, imem_req=0.
    - On inst_ready: pc<=pc+4, fetch_count+1, then go to REQ.
  - DRAIN: imem_req=1 with the old address held. Waits for imem_ack, discards the data, loads pc<=pending target, then goes to REQ.
- Memory protocol:
  - Only one request is outstanding.
  - imem_req and imem_addr stay stable until imem_ack.
  - A request is never withdrawn.
  - imem_ack outside REQ/DRAIN is ignored.
- Decode protocol:
  - The transfer happens when inst_valid and inst_ready are both high.
  - inst_out, inst_pc and opcode_out stay stable while inst_valid=1 and inst_ready=0.
- Throughput: with zero-wait memory (ack in the same cycle as req) and ready tied high, one instruction per 2 cycles (REQ, OUT).
- Redirect handling (highest priority; target low 2 bits zeroed):
  - In REQ without ack: store the target and go to DRAIN.
  - In REQ with ack in the same cycle: discard the data, pc<=target, stay in REQ.
  - In OUT: inst_valid drops next cycle, pc<=target, go to REQ.
    - If inst_ready is high in the same cycle, the transfer still counts and fetch_count increments.
    - pc takes the target, not pc+4.
  - In DRAIN: a new redirect overwrites the stored target (latest wins).
  - In IDLE: pc<=target, go to REQ.
- Arithmetic:
  - pc+4 wraps modulo 2^ADDR_W.
  - fetch_count wraps at 2^32.
- Reset mid-operation: returns to IDLE immediately. A memory ack arriving after reset is ignored.

Optional Feature:
- Macro: INST_FETCH_ILLEGAL_CHECK_EN
- Defined:
  - Adds output port illegal_inst, 1 bit, reset 0.
  - illegal_inst is high with inst_valid when opcode_out is not in {0,4,5,8,12,13,24,25,27}, or when inst_out[1:0] != 2'b11.
  - The instruction is still presented normally; decode/trap logic decides what to do with it.
- Undefined: the port is absent and there is no checking logic.

Decomposition:
- Shared package fetch_pkg:
  - State enum (IDLE, REQ, OUT, DRAIN).
  - Opcode constants OP_LOAD=0, OP_OPIMM=4, OP_AUIPC=5, OP_STORE=8, OP_OP=12, OP_LUI=13, OP_BRANCH=24, OP_JALR=25, OP_JAL=27.
  - INST_STEP=4.
- Optional sub-module inst_legal_check: combinational opcode legality. It is instantiated only under the macro.

Test Plan:
- Reset release, zero-wait memory returning 0x00000013 at 0x0, 0x00100093 at 0x4, ready high:
  - imem_addr sequence is 0x0 then 0x4.
  - inst_pc is 0x0 then 0x4, opcode_out=4.
  - fetch_count=2 after 4 cycles.
- Backpressure: ready low for 5 cycles while inst_valid=1:
  - inst_out, inst_pc and opcode_out are stable.
  - No imem_req is issued.
  - fetch_count is unchanged.
- Memory with 3-cycle ack latency, redirect to 0x103 in the first wait cycle:
  - req stays high with the old address until ack.
  - The data is dropped and inst_valid stays 0.
  - The next request goes to 0x100.
- Redirect in OUT with inst_ready high, same cycle, held instruction at pc 0x8, target 0x40:
  - fetch_count increments.
  - The next imem_addr is 0x40, not 0xC.
- rst_n pulsed low while in DRAIN with a late ack:
  - All outputs return to their reset values.
  - The late ack is ignored.
  - The first request goes to RESET_PC.
- With the macro defined, fetch 0x0000007F (opcode 31):
  - illegal_inst=1 while it is held.
  - 0x00000003 gives illegal_inst=0.
